// File: rtl/carfield_pkg.sv
// carfield_pkg: shared definitions for the Carfield APB watchdog.
//   - byte offsets of the watchdog registers (only bits [4:2] are decoded)
//   - default kick key
//   - watchdog state enum and packed register layouts
package carfield_pkg;

   localparam logic [4:0] WdtCtrlOffset   = 5'h00;
   localparam logic [4:0] WdtLoadOffset   = 5'h04;
   localparam logic [4:0] WdtCountOffset  = 5'h08;
   localparam logic [4:0] WdtKickOffset   = 5'h0C;
   localparam logic [4:0] WdtStatusOffset = 5'h10;
   localparam logic [4:0] WdtPrescOffset  = 5'h14;

   localparam logic [31:0] WdtKickKey = 32'h5A5A_A5A5;

   typedef enum logic [1:0] {
      WdtIdle,
      WdtCount,
      WdtBark,
      WdtBite
   } wdt_state_e;

   // CTRL layout, MSB first so a cast from pwdata[2:0] lines up
   typedef struct packed {
      logic lock;
      logic bite_en;
      logic en;
   } wdt_ctrl_t;

   // Word index of a register inside the 8-entry decode window
   function automatic logic [2:0] wdt_reg_idx(input logic [4:0] offset);
      return offset[4:2];
   endfunction

endpackage

// File: rtl/carfield_wdt_prescaler.sv
// carfield_wdt_prescaler: free-running divider for the watchdog counter.
//   clk, rst : clock, asynchronous active-high reset
//   clear    : force the divider back to 0 (takes priority over enable)
//   enable   : divider advances only while high
//   compare  : divider counts 0..compare and wraps
//   tick     : high for the one cycle where the divider sits at compare
module carfield_wdt_prescaler #(
   parameter int unsigned Width = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clear,
   input  logic             enable,
   input  logic [Width-1:0] compare,
   output logic             tick
);

   localparam logic [Width-1:0] One = Width'(1);

   logic [Width-1:0] presc;

   // >= rather than == so lowering compare below the running value
   // wraps at once instead of running around the full range
   assign tick = enable & (presc >= compare);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         presc <= '0;
      end else if (clear) begin
         presc <= '0;
      end else if (enable) begin
         presc <= tick ? '0 : presc + One;
      end
   end

endmodule

// File: rtl/carfield_apb_wdt.sv
// carfield_apb_wdt: APB watchdog timer with bark interrupt and bite reset.
//   clk_i, rst_i        : clock, asynchronous active-high reset
//   paddr_i .. pwdata_i : APB slave request (only paddr_i[4:2] decoded)
//   prdata_o, pready_o,
//   pslverr_o           : APB response, zero wait states, combinational
//   irq_o               : bark interrupt, level, mirrors STATUS.BARK
//   rst_req_o           : bite reset request, level, held until rst_i
// Registers: CTRL{lock,bite_en,en}, LOAD, COUNT(ro), KICK(wo),
//            STATUS{bitten,bark(w1c)}, PRESC.
module carfield_apb_wdt
   import carfield_pkg::*;
#(
   parameter int unsigned CntWidth   = 32,
   parameter int unsigned PrescWidth = 16,
   parameter logic [31:0] KickKey    = WdtKickKey
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic [31:0] paddr_i,
   input  logic        psel_i,
   input  logic        penable_i,
   input  logic        pwrite_i,
   input  logic [31:0] pwdata_i,
   output logic [31:0] prdata_o,
   output logic        pready_o,
   output logic        pslverr_o,
   output logic        irq_o,
   output logic        rst_req_o
);

   localparam logic [CntWidth-1:0] CntOne = CntWidth'(1);

   // registers
   wdt_ctrl_t             ctrl;
   logic [CntWidth-1:0]   load;
   logic [PrescWidth-1:0] presc_cmp;
   logic                  bark;
   logic                  bitten;

   // counter / fsm
   wdt_state_e            state, state_next;
   logic [CntWidth-1:0]   cnt, cnt_next;
   logic                  tick, presc_run, presc_clr;
   logic                  bark_set, bite_set;

   // apb decode
   logic [2:0] idx;
   logic       access, err, wr_ok;
   logic       sel_ctrl, sel_load, sel_count, sel_kick, sel_status, sel_presc;
   logic       mapped;
   logic       ctrl_wr, load_wr, presc_wr, kick, bark_clr, en_on, en_off;
   logic       unused_addr;

   assign unused_addr = ^{paddr_i[31:5], paddr_i[1:0]};

   assign access     = psel_i & penable_i;
   assign idx        = paddr_i[4:2];
   assign sel_ctrl   = (idx == wdt_reg_idx(WdtCtrlOffset));
   assign sel_load   = (idx == wdt_reg_idx(WdtLoadOffset));
   assign sel_count  = (idx == wdt_reg_idx(WdtCountOffset));
   assign sel_kick   = (idx == wdt_reg_idx(WdtKickOffset));
   assign sel_status = (idx == wdt_reg_idx(WdtStatusOffset));
   assign sel_presc  = (idx == wdt_reg_idx(WdtPrescOffset));
   assign mapped     = sel_ctrl | sel_load | sel_count | sel_kick | sel_status | sel_presc;

   // Error conditions; an erroring write has no side effect at all
   always_comb begin
      err = 1'b0;
      if (!mapped) begin
         err = 1'b1;
      end else if (pwrite_i) begin
         if (sel_count)                                       err = 1'b1;
         if (ctrl.lock && (sel_ctrl || sel_load || sel_presc)) err = 1'b1;
         if (sel_kick && (pwdata_i != KickKey))               err = 1'b1;
      end
   end

   assign pready_o  = 1'b1;
   assign pslverr_o = access & err;
   assign wr_ok     = access & pwrite_i & ~err;

   assign ctrl_wr  = wr_ok & sel_ctrl;
   assign load_wr  = wr_ok & sel_load;
   assign presc_wr = wr_ok & sel_presc;
   assign kick     = wr_ok & sel_kick;
   assign bark_clr = wr_ok & sel_status & pwdata_i[0];
   assign en_on    = ctrl_wr & pwdata_i[0];
   assign en_off   = ctrl_wr & ~pwdata_i[0];

   // Read mux; unmapped and write-only locations read as 0
   always_comb begin
      prdata_o = '0;
      if (psel_i && !pwrite_i) begin
         if (sel_ctrl)   prdata_o[2:0]            = ctrl;
         if (sel_load)   prdata_o[CntWidth-1:0]   = load;
         if (sel_count)  prdata_o[CntWidth-1:0]   = cnt;
         if (sel_status) prdata_o[1:0]            = {bitten, bark};
         if (sel_presc)  prdata_o[PrescWidth-1:0] = presc_cmp;
      end
   end

   // Register file. LOCK only ever goes 0->1: while it is set every
   // CTRL write errors out, so a plain store is set-only in practice.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         ctrl      <= '0;
         load      <= '0;
         presc_cmp <= '0;
         bark      <= 1'b0;
         bitten    <= 1'b0;
      end else begin
         if (ctrl_wr)  ctrl      <= wdt_ctrl_t'(pwdata_i[2:0]);
         if (load_wr)  load      <= pwdata_i[CntWidth-1:0];
         if (presc_wr) presc_cmp <= pwdata_i[PrescWidth-1:0];
         // a fresh bark beats a simultaneous W1C
         if (bark_set)      bark <= 1'b1;
         else if (bark_clr) bark <= 1'b0;
         if (bite_set) bitten <= 1'b1;
      end
   end

   assign irq_o     = bark;
   // bitten is set exactly when BITE is entered and BITE is terminal
   assign rst_req_o = bitten;

   assign presc_run = (state == WdtCount) || (state == WdtBark);

   carfield_wdt_prescaler #(
      .Width(PrescWidth)
   ) i_presc (
      .clk    (clk_i),
      .rst    (rst_i),
      .clear  (presc_clr),
      .enable (presc_run),
      .compare(presc_cmp),
      .tick   (tick)
   );

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state <= WdtIdle;
         cnt   <= '0;
      end else begin
         state <= state_next;
         cnt   <= cnt_next;
      end
   end

   // Only one APB access per cycle, so kick and EN writes never collide.
   // Within a state: EN off first, then kick, then the tick.
   always_comb begin
      state_next = state;
      cnt_next   = cnt;
      presc_clr  = 1'b0;
      bark_set   = 1'b0;
      bite_set   = 1'b0;
      unique case (state)
         WdtIdle: begin
            if (en_on) begin
               state_next = WdtCount;
               cnt_next   = load;
               presc_clr  = 1'b1;
            end else if (kick) begin
               cnt_next = load;
            end
         end
         WdtCount: begin
            if (en_off) begin
               state_next = WdtIdle;
            end else if (kick) begin
               cnt_next = load;
            end else if (tick) begin
               if (cnt == '0) begin
                  state_next = WdtBark;
                  bark_set   = 1'b1;
                  cnt_next   = load;
               end else begin
                  cnt_next = cnt - CntOne;
               end
            end
         end
         WdtBark: begin
            if (en_off) begin
               state_next = WdtIdle;
            end else if (kick) begin
               state_next = WdtCount;
               cnt_next   = load;
            end else if (tick) begin
               if (cnt != '0) begin
                  cnt_next = cnt - CntOne;
               end else if (ctrl.bite_en) begin
                  state_next = WdtBite;
                  bite_set   = 1'b1;
               end else begin
                  // repeated bark without bite: re-arm the interrupt
                  bark_set = 1'b1;
                  cnt_next = load;
               end
            end
         end
         WdtBite: begin
         end
         default: state_next = WdtIdle;
      endcase
   end

endmodule

// File: tb/tb_carfield_apb_wdt.sv
// Scoreboarded bench for carfield_apb_wdt: a driver issues APB traffic and
// pushes, per cycle, the response predicted by a behavioural model; a
// monitor on the falling edge pops and compares.
module tb_carfield_apb_wdt;

   localparam logic [31:0] KEY = 32'h5A5A_A5A5;
   localparam int OFF = 0, RUNNING = 1, BARKED = 2, BITTEN = 3;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] paddr = '0, pwdata = '0;
   logic        psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
   logic [31:0] prdata;
   logic        pready, pslverr, irq, rst_req;

   always #5 clk = ~clk;

   carfield_apb_wdt dut (
      .clk_i    (clk),
      .rst_i    (rst),
      .paddr_i  (paddr),
      .psel_i   (psel),
      .penable_i(penable),
      .pwrite_i (pwrite),
      .pwdata_i (pwdata),
      .prdata_o (prdata),
      .pready_o (pready),
      .pslverr_o(pslverr),
      .irq_o    (irq),
      .rst_req_o(rst_req)
   );

   typedef struct {
      bit          acc;
      bit          rd;
      logic [31:0] prdata;
      bit          err;
      bit          irq;
      bit          rreq;
   } exp_t;

   exp_t q[$];
   int   n_chk = 0, n_err = 0;
   bit   started = 0;

   // behavioural model state
   int          m_mode;
   logic [31:0] m_cnt, m_load;
   int          m_pcmp;
   bit          m_en, m_ben, m_lock, m_bark, m_bitten;
   longint      cyc = 0, t0 = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, want %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic bit m_error(input logic [2:0] idx, input bit wr, input logic [31:0] d);
      if (idx > 3'd5) return 1;
      if (!wr) return 0;
      if (idx == 3'd2) return 1;
      if (m_lock && (idx == 3'd0 || idx == 3'd1 || idx == 3'd5)) return 1;
      if (idx == 3'd3 && d != KEY) return 1;
      return 0;
   endfunction

   function automatic logic [31:0] m_read(input logic [2:0] idx);
      case (idx)
         3'd0: return {29'd0, m_lock, m_ben, m_en};
         3'd1: return m_load;
         3'd2: return m_cnt;
         3'd4: return {30'd0, m_bitten, m_bark};
         3'd5: return m_pcmp;
         default: return 32'd0;
      endcase
   endfunction

   function automatic void m_reset();
      m_mode = OFF; m_cnt = 0; m_load = 0; m_pcmp = 0;
      m_en = 0; m_ben = 0; m_lock = 0; m_bark = 0; m_bitten = 0; t0 = 0;
   endfunction

   // Advance the model across one clock edge using the bus values of the
   // cycle just ending. Prescaler ticks come from elapsed time since the
   // count phase began: every (PRESC+1)-th cycle.
   function automatic void model_step();
      bit          acc, wr, ok, set_bark, tick;
      logic [2:0]  idx;
      logic [31:0] d;
      if (rst) begin
         m_reset();
         return;
      end
      acc = psel & penable; wr = pwrite; idx = paddr[4:2]; d = pwdata;
      ok  = acc && wr && !m_error(idx, wr, d);
      set_bark = 0;
      tick = (m_mode == RUNNING || m_mode == BARKED) &&
             ((cyc - t0) % (m_pcmp + 1) == m_pcmp);
      case (m_mode)
         OFF: begin
            if (ok && idx == 0 && d[0]) begin
               m_mode = RUNNING; m_cnt = m_load; t0 = cyc + 1;
            end else if (ok && idx == 3) m_cnt = m_load;
         end
         RUNNING, BARKED: begin
            if (ok && idx == 0 && !d[0]) m_mode = OFF;
            else if (ok && idx == 3) begin
               m_cnt = m_load; m_mode = RUNNING;
            end else if (tick && m_cnt != 0) m_cnt = m_cnt - 1;
            else if (tick && m_mode == RUNNING) begin
               m_mode = BARKED; set_bark = 1; m_cnt = m_load;
            end else if (tick && m_ben) begin
               m_mode = BITTEN; m_bitten = 1;
            end else if (tick) begin
               set_bark = 1; m_cnt = m_load;
            end
         end
         default: ;
      endcase
      if (ok && idx == 0) begin
         m_en = d[0]; m_ben = d[1]; m_lock = m_lock | d[2];
      end
      if (ok && idx == 1) m_load = d;
      if (ok && idx == 5) m_pcmp = d[15:0];
      if (ok && idx == 4 && d[0]) m_bark = 0;
      if (set_bark) m_bark = 1;
   endfunction

   task automatic push_exp();
      exp_t e;
      e.acc = psel & penable;
      e.rd  = e.acc & ~pwrite;
      if (rst) begin
         e.acc = 0; e.rd = 0; e.prdata = 0; e.err = 0; e.irq = 0; e.rreq = 0;
      end else begin
         e.prdata = m_read(paddr[4:2]);
         e.err    = m_error(paddr[4:2], pwrite, pwdata);
         e.irq    = m_bark;
         e.rreq   = m_bitten;
      end
      q.push_back(e);
   endtask

   // Close the current cycle: record its expectation, take the edge.
   task automatic cycle_end();
      push_exp();
      @(posedge clk);
      model_step();
      cyc++;
      #1;
   endtask

   always @(negedge clk) begin
      if (started) begin
         exp_t e;
         if (q.size() == 0) begin
            n_chk++; n_err++;
            $display("FAIL scoreboard_empty: got none, want one entry (t=%0t)", $time);
         end else begin
            e = q.pop_front();
            check("irq_o", irq, e.irq);
            check("rst_req_o", rst_req, e.rreq);
            check("pready_o", pready, 1);
            if (e.acc) check("pslverr_o", pslverr, e.err);
            if (e.rd)  check("prdata_o", prdata, e.prdata);
         end
      end
   end

   task automatic apb(input logic [31:0] addr, input bit wr, input logic [31:0] data,
                      output logic [31:0] rd, output logic er);
      paddr = addr; pwrite = wr; pwdata = wr ? data : $urandom;
      psel = 1; penable = 0;
      cycle_end();
      penable = 1;
      #1;
      rd = prdata; er = pslverr;
      cycle_end();
      psel = 0; penable = 0; pwrite = 0;
   endtask

   task automatic wr_reg(input logic [31:0] addr, input logic [31:0] data);
      logic [31:0] r; logic e;
      apb(addr, 1, data, r, e);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cycle_end();
   endtask

   task automatic do_reset(input bit chk_async);
      rst = 1; psel = 0; penable = 0;
      #1;
      if (chk_async) begin
         check("async_irq", irq, 0);
         check("async_rst_req", rst_req, 0);
         check("async_pslverr", pslverr, 0);
         check("async_prdata", prdata, 0);
         check("async_pready", pready, 1);
      end
      cycle_end(); cycle_end();
      rst = 0;
   endtask

   // k = 1 in the cycle right after the enabling access phase
   task automatic wait_level(input bit want_bite, input int limit, output int k);
      k = 1;
      while (!(want_bite ? rst_req : irq) && k <= limit) begin
         cycle_end(); k++;
      end
   endtask

   initial begin
      logic [31:0] r, a, d;
      logic        e;
      int          k, k2, g, op;

      m_reset();
      @(posedge clk); #1;
      started = 1;
      do_reset(1);

      // reset values of every register, then an unmapped offset
      for (int i = 0; i < 6; i++) begin
         apb(32'(i * 4), 0, 0, r, e);
         check("reset_read", r, 0);
      end
      apb(32'h18, 0, 0, r, e);
      check("unmapped_err", e, 1);
      check("unmapped_data", r, 0);

      // first bark: LOAD=3, PRESC=0 -> T+5
      wr_reg(32'h04, 3); wr_reg(32'h14, 0); wr_reg(32'h00, 1);
      wait_level(0, 50, k);
      check("bark_latency", k, 5);
      do_reset(0);

      // COUNT readback while running
      wr_reg(32'h04, 3); wr_reg(32'h00, 1);
      for (int i = 0; i < 4; i++) apb(32'h08, 0, 0, r, e);
      do_reset(0);

      // bite: bark at T+5, bite at T+9; kick afterwards is ignored
      wr_reg(32'h04, 3); wr_reg(32'h00, 3);
      wait_level(0, 50, k);
      wait_level(1, 50, k2);
      check("bite_latency", k + k2 - 1, 9);
      apb(32'h10, 0, 0, r, e);
      check("status_after_bite", r, 3);
      apb(32'h0C, 1, KEY, r, e);
      check("kick_in_bite_err", e, 0);
      wr_reg(32'h00, 0);
      idle(6);
      do_reset(0);

      // kick lands in the cycle where cnt==0 and a tick occurs
      wr_reg(32'h04, 3); wr_reg(32'h00, 1);
      g = 0;
      while (!(m_mode == RUNNING && m_cnt == 1) && g < 50) begin cycle_end(); g++; end
      check("kick_window_found", g < 50, 1);
      apb(32'h0C, 1, KEY, r, e);
      check("kick_good_err", e, 0);
      idle(2);
      apb(32'h0C, 1, 32'h1234, r, e);
      check("kick_bad_err", e, 1);
      idle(3);
      do_reset(0);

      // lock
      wr_reg(32'h00, 4);
      apb(32'h04, 1, 7, r, e);
      check("locked_load_err", e, 1);
      apb(32'h04, 0, 0, r, e);
      check("locked_load_val", r, 0);
      apb(32'h00, 1, 0, r, e);
      check("locked_ctrl_err", e, 1);
      apb(32'h00, 0, 0, r, e);
      check("lock_sticky", r, 4);
      do_reset(0);
      apb(32'h00, 0, 0, r, e);
      check("lock_cleared", r, 0);

      // PRESC=2, LOAD=1 -> bark 1+(1+1)*(2+1) cycles after the access
      wr_reg(32'h14, 2); wr_reg(32'h04, 1); wr_reg(32'h00, 1);
      wait_level(0, 50, k);
      check("presc_bark_latency", k, 7);
      idle(4);
      do_reset(1);

      // randomized traffic
      for (int it = 0; it < 700; it++) begin
         op = $urandom_range(0, 99);
         a = $urandom;
         if (op < 20) idle($urandom_range(1, 8));
         else if (op < 30) begin
            d = $urandom & 32'hFFFF_FFF8;
            d[1:0] = 2'($urandom_range(0, 3));
            d[2] = ($urandom_range(0, 29) == 0);
            wr_reg({a[31:5], 3'd0, a[1:0]}, d);
         end else if (op < 40) begin
            d = ($urandom_range(0, 3) == 0) ? $urandom : $urandom_range(0, 6);
            wr_reg({a[31:5], 3'd1, a[1:0]}, d);
         end else if (op < 48) begin
            if (m_mode == OFF || m_mode == BITTEN) wr_reg(32'h14, $urandom_range(0, 3));
            else idle(1);
         end else if (op < 68) begin
            d = ($urandom_range(0, 4) == 0) ? $urandom : KEY;
            wr_reg({a[31:5], 3'd3, a[1:0]}, d);
         end else if (op < 75) begin
            wr_reg({a[31:5], 3'd4, a[1:0]}, $urandom);
         end else if (op < 80) begin
            g = $urandom_range(0, 2);
            wr_reg({a[31:5], (g == 0) ? 3'd2 : (g == 1) ? 3'd6 : 3'd7, a[1:0]}, $urandom);
         end else if (op < 97) begin
            apb(a, 0, 0, r, e);
         end else begin
            do_reset($urandom_range(0, 1));
         end
      end

      idle(2);
      started = 0;
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL global_timeout: run did not finish");
      $fatal(1, "timeout");
   end

endmodule
